// File: rtl/keypad_scan_if.sv
// Keypad scanner bundle: row returns in, column drive and key report out.
// The master side is the panel/consumer, the slave side is the scanner.
interface keypad_scan_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEY;
    logic       KEY_VALID;
    logic       PRESSED;

    modport master (
        output ROW,
        input  COL, KEY, KEY_VALID, PRESSED
    );

    modport slave (
        input  ROW,
        output COL, KEY, KEY_VALID, PRESSED
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner for the charger front panel.
// One-hot column drive, synchronised rows, tick-based press/release debounce.
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input logic         CLK,
    input logic         rst,
    keypad_scan_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, rs;
    logic [CW-1:0] pcnt;
    logic          tick;
    logic [1:0]    col, col_n;
    logic [1:0]    row, row_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [DW:0]   inc;
    logic [3:0]    key, key_n;
    logic          kv, kv_n;
    logic          pressed, pressed_n;
    logic          hit;

    assign tick = (pcnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            rs      <= '0;
            pcnt    <= '0;
            state   <= SCAN;
            col     <= '0;
            row     <= '0;
            dcnt    <= '0;
            key     <= '0;
            kv      <= 1'b0;
            pressed <= 1'b0;
        end else begin
            sync1   <= bus.ROW;
            rs      <= sync1;
            pcnt    <= tick ? '0 : pcnt + CW'(1);
            state   <= state_n;
            col     <= col_n;
            row     <= row_n;
            dcnt    <= dcnt_n;
            key     <= key_n;
            kv      <= kv_n;
            pressed <= pressed_n;
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        dcnt_n    = dcnt;
        key_n     = key;
        kv_n      = 1'b0;
        pressed_n = pressed;
        inc       = {1'b0, dcnt} + (DW + 1)'(1);
        hit       = rs[row];
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (rs == 4'd0) begin
                        col_n = col + 2'd1;
                    end else begin
                        // lowest active row wins within the frozen column
                        if (rs[0])      row_n = 2'd0;
                        else if (rs[1]) row_n = 2'd1;
                        else if (rs[2]) row_n = 2'd2;
                        else            row_n = 2'd3;
                        dcnt_n  = DW'(1);
                        state_n = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (hit) begin
                        if (int'(inc) >= DEBOUNCE_CNT) begin
                            key_n     = {row, col};
                            kv_n      = 1'b1;
                            pressed_n = 1'b1;
                            dcnt_n    = '0;
                            state_n   = HOLD;
                        end else begin
                            dcnt_n = inc[DW-1:0];
                        end
                    end else begin
                        dcnt_n  = '0;
                        col_n   = col + 2'd1;
                        state_n = SCAN;
                    end
                end
                HOLD: begin
                    if (!hit) begin
                        dcnt_n  = DW'(1);
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!hit) begin
                        if (int'(inc) >= DEBOUNCE_CNT) begin
                            pressed_n = 1'b0;
                            dcnt_n    = '0;
                            col_n     = col + 2'd1;
                            state_n   = SCAN;
                        end else begin
                            dcnt_n = inc[DW-1:0];
                        end
                    end else begin
                        state_n = HOLD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    assign bus.COL       = 4'b0001 << col;
    assign bus.KEY       = key;
    assign bus.KEY_VALID = kv;
    assign bus.PRESSED   = pressed;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, key scoreboard, tick-aligned
// press/release/bounce/reset scenarios.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DC = 3;

    logic        CLK;
    logic        rst;
    logic [15:0] keys;
    int          n_chk;
    int          n_pass;
    int          pc;
    logic        prev_kv;
    logic [3:0]  exp_q[$];

    keypad_scan_if bus();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // keypad matrix: a row reads high when a pressed key sits in the driven column
    always_comb begin
        bus.ROW = '0;
        for (int r = 0; r < 4; r++)
            bus.ROW[r] = |(keys[r*4 +: 4] & bus.COL);
    end

    // reference scan-tick phase; pc==0 at a negedge means a tick edge just passed
    always @(posedge CLK or posedge rst) begin
        if (rst) pc <= 0;
        else     pc <= (pc == SD - 1) ? 0 : pc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    always @(negedge CLK) begin
        if (!rst) begin
            chk("col_onehot", 32'($onehot(bus.COL)), 1);
            if (prev_kv)
                chk("kv_width", bus.KEY_VALID, 0);
            if (bus.KEY_VALID) begin
                if (exp_q.size() > 0)
                    chk("key", bus.KEY, exp_q.pop_front());
                else
                    chk("spurious_kv", bus.KEY_VALID, 0);
            end
            prev_kv = bus.KEY_VALID;
        end else begin
            prev_kv = 1'b0;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge CLK);
            while (pc != 0) @(negedge CLK);
        end
    endtask

    task automatic wait_col(input logic [3:0] c);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (pc == 0 && bus.COL == c) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_col", ok, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_col"}, bus.COL, 4'b0001);
        chk({tag, "_key"}, bus.KEY, 0);
        chk({tag, "_kv"}, bus.KEY_VALID, 0);
        chk({tag, "_pr"}, bus.PRESSED, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [4];
        logic [3:0] prev;
        int         n;
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n_chk   = 0;
        n_pass  = 0;
        prev_kv = 1'b0;
        keys    = '0;
        rst     = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_vals("rst0");
        rst = 1'b0;

        // idle scanning
        for (int i = 0; i < 4; i++) begin
            prev = bus.COL;
            n = 0;
            while (bus.COL == prev && n < 20) begin
                @(negedge CLK);
                n++;
            end
            chk("idle_period", n, SD);
            chk("idle_col", bus.COL, seq[i]);
            chk("idle_pr", bus.PRESSED, 0);
        end

        // row1/col2 press and clean release
        wait_col(4'b0100);
        keys[6] = 1'b1;
        exp_q.push_back(4'd6);
        wait_ticks(2);
        chk("db_pr", bus.PRESSED, 0);
        chk("db_col", bus.COL, 4'b0100);
        wait_ticks(1);
        chk("acc_pr", bus.PRESSED, 1);
        chk("acc_key", bus.KEY, 6);
        wait_ticks(3);
        chk("hold_col", bus.COL, 4'b0100);
        chk("hold_pr", bus.PRESSED, 1);
        keys = '0;
        wait_ticks(2);
        chk("rel_early_pr", bus.PRESSED, 1);
        wait_ticks(1);
        chk("rel_pr", bus.PRESSED, 0);
        chk("rel_col", bus.COL, 4'b1000);

        // one-tick press bounce
        wait_col(4'b0001);
        keys[8] = 1'b1;
        wait_ticks(1);
        keys = '0;
        wait_ticks(1);
        chk("bnc_col", bus.COL, 4'b0010);
        chk("bnc_pr", bus.PRESSED, 0);
        chk("bnc_key", bus.KEY, 6);

        // release bounce back to HOLD
        wait_col(4'b0100);
        keys[14] = 1'b1;
        exp_q.push_back(4'd14);
        wait_ticks(3);
        chk("rb_acc_pr", bus.PRESSED, 1);
        chk("rb_acc_key", bus.KEY, 14);
        keys = '0;
        wait_ticks(1);
        keys[14] = 1'b1;
        wait_ticks(1);
        chk("rb_hold_pr", bus.PRESSED, 1);
        keys = '0;
        wait_ticks(2);
        chk("rb_early_pr", bus.PRESSED, 1);
        chk("rb_early_col", bus.COL, 4'b0100);
        wait_ticks(1);
        chk("rb_rel_pr", bus.PRESSED, 0);
        chk("rb_rel_col", bus.COL, 4'b1000);

        // rows 0 and 3 in column 3, then ignored extra keys
        wait_col(4'b1000);
        keys[3]  = 1'b1;
        keys[15] = 1'b1;
        exp_q.push_back(4'd3);
        wait_ticks(3);
        chk("multi_key", bus.KEY, 3);
        chk("multi_pr", bus.PRESSED, 1);
        keys[1] = 1'b1;
        keys[7] = 1'b1;
        wait_ticks(3);
        chk("ign_key", bus.KEY, 3);
        chk("ign_col", bus.COL, 4'b1000);
        keys = '0;
        wait_ticks(3);
        chk("multi_rel_pr", bus.PRESSED, 0);
        chk("multi_rel_col", bus.COL, 4'b0001);

        // reset during DEBOUNCE
        wait_col(4'b0010);
        keys[5] = 1'b1;
        wait_ticks(2);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_db");
        keys = '0;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        chk("rst_db_resume0", bus.COL, 4'b0001);
        wait_ticks(1);
        chk("rst_db_resume1", bus.COL, 4'b0010);

        // reset during HOLD
        wait_col(4'b0010);
        keys[5] = 1'b1;
        exp_q.push_back(4'd5);
        wait_ticks(3);
        chk("h_acc_key", bus.KEY, 5);
        chk("h_acc_pr", bus.PRESSED, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_hold");
        keys = '0;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        chk("rst_h_resume0", bus.COL, 4'b0001);
        wait_ticks(1);
        chk("rst_h_resume1", bus.COL, 4'b0010);
        wait_ticks(1);
        chk("rst_h_resume2", bus.COL, 4'b0100);

        repeat (4) @(negedge CLK);
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad for the coin charger front panel: one-hot column drive, reads row returns, debounces a press, emits a 4-bit key code with a one-cycle valid strobe.
- It is the input-side counterpart to the time-multiplexed 7-segment display driver: both rotate a one-hot select and share a slow scan tick.
- Its KEY/KEY_VALID outputs feed the charger control FSM.

Parameters:
- SCAN_DIV, 1000: CLK cycles per scan tick. Legal range >= 2.
- DEBOUNCE_CNT, 4: consecutive agreeing ticks required to accept a press or a release. Legal range >= 1.

Ports:
- CLK  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ROW  input  4  row returns, active-high; bit r = row r. Asynchronous to CLK.
- COL  output  4  column drive, one-hot, active-high; bit c = column c.
- KEY  output  4  last accepted key code = row*4 + col.
- KEY_VALID  output  1  one-CLK pulse when a new key is accepted.
- PRESSED  output  1  high from acceptance until the release is accepted.

Behaviour:
- ROW passes through a 2-flop synchroniser; all decisions use the synchronised value RS.
- Prescaler:
  - Counter width $clog2(SCAN_DIV), counts 0..SCAN_DIV-1 and wraps.
  - tick = 1 for one CLK when count == SCAN_DIV-1.
  - The prescaler free-runs in every state.
- Reset values: COL=4'b0001, column index 0, KEY=0, KEY_VALID=0, PRESSED=0, state SCAN, prescaler 0, debounce counter 0, latched row 0.
- Reset mid-operation returns to these values immediately. No KEY_VALID pulse is issued for a press in progress.
- States: SCAN, DEBOUNCE, HOLD, RELEASE. All transitions occur only on tick, except that KEY_VALID is cleared on the next CLK.
- SCAN, on tick:
  - RS == 0: column index increments mod 4 (3 wraps to 0); COL follows.
  - RS != 0: latch the lowest set row index as r, keep the column frozen, debounce counter = 1, go to DEBOUNCE.
- DEBOUNCE, on tick:
  - RS[r] == 1: counter++. When the counter reaches DEBOUNCE_CNT, set KEY = {r[1:0], col[1:0]}, pulse KEY_VALID, set PRESSED=1, go to HOLD.
  - RS[r] == 0: counter cleared, go to SCAN, column advances.
  - With DEBOUNCE_CNT=1, acceptance happens on the first DEBOUNCE tick.
- HOLD, on tick:
  - RS[r] == 1: stay.
  - RS[r] == 0: counter = 1, go to RELEASE.
  - Other rows pressed in the same column, or keys in other columns, are ignored (no rollover).
- RELEASE, on tick:
  - RS[r] == 0: counter++. When it reaches DEBOUNCE_CNT, PRESSED=0, go to SCAN, column advances.
  - RS[r] == 1 (bounce): go back to HOLD. No new KEY_VALID.
- KEY holds its value until the next acceptance. KEY_VALID is exactly 1 CLK wide and never asserted outside the DEBOUNCE->HOLD transition.
- COL is always exactly one-hot. It changes only on tick and only in SCAN, or when leaving DEBOUNCE/RELEASE to SCAN.
- Simultaneous presses in one column: the lowest row wins.

Test Plan:
- Reset, then idle with SCAN_DIV=4 and ROW=0:
  - COL cycles 0001->0010->0100->1000->0001, changing every 4 CLKs.
  - KEY_VALID stays 0, PRESSED=0.
- Press row1/col2 (ROW=0010 only while COL=0100, held), DEBOUNCE_CNT=3:
  - Exactly one KEY_VALID pulse with KEY=6.
  - PRESSED=1, COL frozen at 0100 while held.
  - After release plus 3 clear ticks, PRESSED=0 and COL advances to 1000.
- Bounce: row asserted for 1 tick, then 0, DEBOUNCE_CNT=3:
  - No KEY_VALID, return to SCAN, KEY unchanged.
- Release bounce in RELEASE (row clear 1 tick, set 1 tick, then clear):
  - Returns to HOLD, no second KEY_VALID.
  - Final release is accepted only after 3 consecutive clear ticks.
- Rows 0 and 3 both active in column 3: KEY=3 (row 0 wins). A second key in column 1 during HOLD is ignored.
- Assert rst during DEBOUNCE and during HOLD:
  - All outputs return to their reset values asynchronously, with no KEY_VALID pulse.
  - Scanning resumes from COL=0001 after rst deasserts.
